md_unit: RTL

- Parametrised multiply/divide unit with architectural HI/LO registers; the multi-cycle companion to the pipeline's combinational ALU.
- Sits beside the ALU in the EX stage.
- Accepts mult/div/mthi/mtlo from EX and raises `busy` so the hazard unit stalls mfhi/mflo and further md ops.
- Supports `flush` so an exception in a later stage can cancel an in-flight op.

---
 rtl/md_unit_if.sv | 16 +
 rtl/md_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, src_a, src_b, flush, input busy, hi, lo);
    modport slave  (input start, op, src_a, src_b, flush, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MD_MADD_EN is defined.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset_n,
    md_unit_if.slave  md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;

    logic               is_mult_s, is_div_s;
    logic [2*WIDTH-1:0] prod_s_s, prod_u_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s, sdiv_s, udiv_s, mq_s, mr_s, sq_s, sr_s, uq_s, ur_s;

    // Classify the incoming op into the multi-cycle classes.
    always_comb begin
        is_mult_s = 1'b0;
        is_div_s  = 1'b0;
        case (md.op)
            OP_MULT, OP_MULTU: is_mult_s = 1'b1;
            OP_DIV, OP_DIVU:   is_div_s  = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mult_s = 1'b1;
`endif
            default: begin
                is_mult_s = 1'b0;
                is_div_s  = 1'b0;
            end
        endcase
    end

    // Result datapath from latched operands; signed divide works on magnitudes
    // so MIN / -1 naturally yields MIN with zero remainder.
    always_comb begin
        prod_s_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u_s = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        abs_a_s  = a_q[WIDTH-1] ? (~a_q + WIDTH'(1)) : a_q;
        abs_b_s  = b_q[WIDTH-1] ? (~b_q + WIDTH'(1)) : b_q;
        sdiv_s   = (abs_b_s == {WIDTH{1'b0}}) ? WIDTH'(1) : abs_b_s;
        udiv_s   = (b_q == {WIDTH{1'b0}}) ? WIDTH'(1) : b_q;
        mq_s     = abs_a_s / sdiv_s;
        mr_s     = abs_a_s % sdiv_s;
        sq_s     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~mq_s + WIDTH'(1)) : mq_s;
        sr_s     = a_q[WIDTH-1] ? (~mr_s + WIDTH'(1)) : mr_s;
        uq_s     = a_q / udiv_s;
        ur_s     = a_q % udiv_s;
    end

    // Next-state, counter, operand latch and HI/LO update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (md.start && !md.flush) begin
                    if (is_mult_s || is_div_s) begin
                        op_d    = md.op;
                        a_d     = md.src_a;
                        b_d     = md.src_b;
                        cnt_d   = is_mult_s ? MULT_N : DIV_N;
                        state_d = S_RUN;
                    end else if (md.op == OP_MTHI) begin
                        hi_d = md.src_a;
                    end else if (md.op == OP_MTLO) begin
                        lo_d = md.src_a;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (md.flush) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                    // A zero divisor burns the full latency but leaves HI/LO alone.
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u_s;
                        OP_DIV: begin
                            if (b_q != {WIDTH{1'b0}}) begin
                                hi_d = sr_s;
                                lo_d = sq_s;
                            end else begin
                                hi_d = hi_q;
                            end
                        end
                        OP_DIVU: begin
                            if (b_q != {WIDTH{1'b0}}) begin
                                hi_d = ur_s;
                                lo_d = uq_s;
                            end else begin
                                hi_d = hi_q;
                            end
                        end
`ifdef MD_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s_s;
                        OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u_s;
                        OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s_s;
                        OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u_s;
`endif
                        default: hi_d = hi_q;
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and architectural registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            op_q    <= 4'd0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy = (state_q == S_RUN);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule
